demux32_q2: RTL and testbench
=============================

Name: demux32_q2

Overview:
- Registered 1-to-2 demultiplexer for the datapath. It is the distributing counterpart of the 2-to-1 select muxes: one 32-bit producer stream is steered to one of two consumer channels, chosen per word by a select bit.
- Each destination channel has its own small FIFO, so a stalled consumer does not block words headed to the other channel while the head word targets a free channel.
- Sits between an execute-stage result source and two write-back consumers, for example the register-file write port and the HI/LO unit.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, at least 2.
- CNTW, 2, occupancy count width; must hold the value DEPTH (log2(DEPTH)+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  word will be accepted this cycle.
- in_data  in  [0:WIDTH-1]  word; bit 0 is MSB.
- in_sel  in  1  destination: 0 selects out0, 1 selects out1.
- out0_valid  out  1  out0 FIFO head valid.
- out0_ready  in  1  consumer 0 takes head.
- out0_data  out  [0:WIDTH-1]  out0 FIFO head.
- out1_valid  out  1  out1 FIFO head valid.
- out1_ready  in  1  consumer 1 takes head.
- out1_data  out  [0:WIDTH-1]  out1 FIFO head.
- out0_count  out  CNTW  out0 FIFO occupancy.
- out1_count  out  CNTW  out1 FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both FIFOs are emptied; all pointers and counts are cleared.
  - outN_valid=0, outN_data=0, outN_count=0.
  - in_ready=0 while rst_n is low, and 1 from the first cycle after release.
- Reset asserted mid-operation discards all queued words with no partial drain. Outputs are 0 immediately, without waiting for a clock edge.
- in_ready = NOT full(in_sel). This is combinational on in_sel and the registered counts.
  - in_ready does not depend on outN_ready. There is no pass-through into a full FIFO, even if a pop happens in the same cycle.
- Accept: when in_valid & in_ready, in_data is written to the FIFO selected by in_sel at the rising edge.
- When in_valid=0, in_sel and in_data are ignored.
- Latency: a word accepted at edge k appears on outN_data with outN_valid=1 after edge k, provided that FIFO was empty. Minimum one cycle; no combinational in-to-out path.
- Pop: when outN_valid & outN_ready, the head is removed at the edge.
  - outN_ready while outN_valid=0 has no effect.
- outN_valid = (outN_count != 0).
  - outN_data is the head entry when valid; its value is don't-care when invalid.
  - outN_data stays stable while outN_valid=1 and outN_ready=0.
- Ordering: per-channel FIFO order is preserved. No ordering guarantee exists between channels.
- Simultaneous push and pop on the same FIFO (not full): the count is unchanged and both operations take effect.
- Simultaneous push and pop on the same FIFO when it was full: only the pop occurs, because in_ready was 0. Count becomes DEPTH-1.
- Push to one channel and pop from the other in the same cycle: both are independent.
- Pointers wrap modulo DEPTH; the count saturates by construction and never exceeds DEPTH.
- Head-of-line: the producer is stalled only while the current word's destination FIFO is full. The other channel continues to drain.

Test Plan:
- Reset, then in_valid=1, in_sel=0, in_data=32'hDEADBEEF for one cycle with out0_ready=0 → next cycle: out0_valid=1, out0_data=DEADBEEF, out0_count=1. out1_valid=0.
- Fill channel 1: with out1_ready=0, push 32'h1, 32'h2 (sel=1) → out1_count=2 and in_ready=0 while in_sel=1. Switching in_sel=0 → in_ready=1 in the same cycle.
- Drain with order check: raise out1_ready → out1_data reads 1 then 2 on consecutive cycles; out1_count goes 2,1,0; out1_valid drops after the second pop.
- Full with simultaneous push and pop: out0 holds 2 words, in_valid=1, in_sel=0, out0_ready=1 → in_ready=0, no write, count 2→1. Next cycle the push is accepted and the count stays 1.
- Interleave: push A(sel0), B(sel1), C(sel0) with both consumers ready → out0 gets A then C, out1 gets B, each valid one cycle after its accept. Counts never exceed 1.
- Async reset mid-operation: with both FIFOs at count 2, pull rst_n low between edges → all outN_valid/outN_count go to 0 immediately. After release, a fresh push of 32'h5 on sel=1 appears alone on out1.

Source files
------------

// File: rtl/demux32_q2.sv
// Registered 1-to-2 demultiplexer. A single producer stream is steered per
// word by in_sel into one of two independent output FIFOs, so a stalled
// consumer only blocks words headed to its own channel.
module demux32_q2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [0:WIDTH-1] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [0:WIDTH-1] out1_data,
  output logic [CNTW-1:0]  out0_count,
  output logic [CNTW-1:0]  out1_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:WIDTH-1] mem_q  [2][DEPTH];
  logic [0:WIDTH-1] mem_d  [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CNTW-1:0]  cnt_q  [2];
  logic [CNTW-1:0]  cnt_d  [2];
  logic             ready_q;
  logic             ready_d;
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       sel_oh;
  logic [1:0]       out_rdy;

  // Acceptance, push/pop decisions and next-state for both FIFOs.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    push    = '0;
    pop     = '0;
    full    = '0;
    sel_oh  = {in_sel, ~in_sel};
    out_rdy = {out1_ready, out0_ready};
    for (int unsigned ch = 0; ch < 2; ch++) begin
      full[ch] = (cnt_q[ch] == CNTW'(DEPTH));
    end
    // Readiness looks only at the registered count: a same-cycle pop never
    // frees space for the incoming word.
    in_ready = ready_q & ~(in_sel ? full[1] : full[0]);
    for (int unsigned ch = 0; ch < 2; ch++) begin
      push[ch] = in_valid & in_ready & sel_oh[ch];
      pop[ch]  = (cnt_q[ch] != '0) & out_rdy[ch];
      if (push[ch]) begin
        mem_d[ch][wptr_q[ch]] = in_data;
        wptr_d[ch]            = wptr_q[ch] + PW'(1);
      end
      if (pop[ch]) begin
        rptr_d[ch] = rptr_q[ch] + PW'(1);
      end
      cnt_d[ch] = cnt_q[ch] + CNTW'(push[ch]) - CNTW'(pop[ch]);
    end
  end

  // Control state: pointers, counts and the post-reset ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        wptr_q[ch] <= '0;
        rptr_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage needs no reset: contents are only visible while the count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head presentation; data is forced to zero when a channel is empty.
  always_comb begin
    out0_valid = (cnt_q[0] != '0);
    out1_valid = (cnt_q[1] != '0);
    out0_data  = out0_valid ? mem_q[0][rptr_q[0]] : '0;
    out1_data  = out1_valid ? mem_q[1][rptr_q[1]] : '0;
    out0_count = cnt_q[0];
    out1_count = cnt_q[1];
  end

endmodule

// File: tb/tb_demux32_q2.sv
// Self-checking bench for demux32_q2: directed scenario tasks plus a
// per-channel scoreboard that follows every accepted and popped word.
module tb_demux32_q2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_data;
  logic        in_sel;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [0:31] out0_data, out1_data;
  logic [1:0]  out0_count, out1_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_w;

  demux32_q2 #(.WIDTH(32), .DEPTH(2), .CNTW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: pops are checked against the queue head, accepts are queued.
  always @(posedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL sb_pop0: popped %h, expected no word", out0_data);
        end else begin
          exp_w = q0.pop_front();
          if (out0_data !== exp_w) begin
            errors++; $display("FAIL sb_pop0: got %h expected %h", out0_data, exp_w);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL sb_pop1: popped %h, expected no word", out1_data);
        end else begin
          exp_w = q1.pop_front();
          if (out1_data !== exp_w) begin
            errors++; $display("FAIL sb_pop1: got %h expected %h", out1_data, exp_w);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  // Occupancy must always match the scoreboard depth.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (out0_count !== 2'(q0.size()) || out1_count !== 2'(q1.size()) ||
          out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin
        errors++;
        $display("FAIL sb_count: got c0=%0d c1=%0d v0=%b v1=%b expected c0=%0d c1=%0d",
                 out0_count, out1_count, out0_valid, out1_valid, q0.size(), q1.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 ||
        out0_data !== 32'h0 || out1_data !== 32'h0 || out0_count !== 2'd0 || out1_count !== 2'd0) begin
      errors++; $display("FAIL reset_state: rdy=%b v0=%b v1=%b d0=%h d1=%h c0=%0d c1=%0d expected all 0",
                         in_ready, out0_valid, out1_valid, out0_data, out1_data, out0_count, out1_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    push(1'b0, 32'hDEADBEEF);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF || out0_count !== 2'd1 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency: v0=%b d0=%h c0=%0d v1=%b expected 1 DEADBEEF 1 0",
                         out0_valid, out0_data, out0_count, out1_valid);
    end
    out0_ready = 1'b1; tick(); out0_ready = 1'b0;
    checks++;
    if (out0_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: v0=%b expected 0", out0_valid);
    end
  endtask

  task automatic test_fill_drain();
    push(1'b1, 32'h1);
    push(1'b1, 32'h2);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h3; #1;
    checks++;
    if (out1_count !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: c1=%0d rdy=%b expected 2 0", out1_count, in_ready);
    end
    in_sel = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_other_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b0;
    out1_ready = 1'b1;
    checks++;
    if (out1_data !== 32'h1 || out1_count !== 2'd2) begin
      errors++; $display("FAIL drain_first: d1=%h c1=%0d expected 1 2", out1_data, out1_count);
    end
    tick();
    checks++;
    if (out1_data !== 32'h2 || out1_count !== 2'd1) begin
      errors++; $display("FAIL drain_second: d1=%h c1=%0d expected 2 1", out1_data, out1_count);
    end
    tick();
    checks++;
    if (out1_valid !== 1'b0 || out1_count !== 2'd0) begin
      errors++; $display("FAIL drain_empty: v1=%b c1=%0d expected 0 0", out1_valid, out1_count);
    end
    out1_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    push(1'b0, 32'hA0);
    push(1'b0, 32'hA1);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA2; out0_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0 || out0_count !== 2'd2) begin
      errors++; $display("FAIL full_pp_block: rdy=%b c0=%0d expected 0 2", in_ready, out0_count);
    end
    tick();
    checks++;
    if (out0_count !== 2'd1 || in_ready !== 1'b1 || out0_data !== 32'hA1) begin
      errors++; $display("FAIL full_pp_pop: c0=%0d rdy=%b d0=%h expected 1 1 A1", out0_count, in_ready, out0_data);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out0_count !== 2'd1 || out0_data !== 32'hA2) begin
      errors++; $display("FAIL full_pp_both: c0=%0d d0=%h expected 1 A2", out0_count, out0_data);
    end
    tick();
    out0_ready = 1'b0;
  endtask

  task automatic test_interleave();
    out0_ready = 1'b1; out1_ready = 1'b1;
    push(1'b0, 32'hAAAA0001);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA0001 || out1_valid !== 1'b0) begin
      errors++; $display("FAIL ilv_a: v0=%b d0=%h v1=%b expected 1 AAAA0001 0", out0_valid, out0_data, out1_valid);
    end
    push(1'b1, 32'hBBBB0002);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hBBBB0002 || out0_valid !== 1'b0) begin
      errors++; $display("FAIL ilv_b: v1=%b d1=%h v0=%b expected 1 BBBB0002 0", out1_valid, out1_data, out0_valid);
    end
    push(1'b0, 32'hCCCC0003);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hCCCC0003 || out1_valid !== 1'b0 ||
        out0_count > 2'd1 || out1_count > 2'd1) begin
      errors++; $display("FAIL ilv_c: v0=%b d0=%h v1=%b c0=%0d c1=%0d expected 1 CCCC0003 0 <=1 <=1",
                         out0_valid, out0_data, out1_valid, out0_count, out1_count);
    end
    tick();
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push(1'b0, 32'h10); push(1'b1, 32'h11);
    push(1'b0, 32'h12); push(1'b1, 32'h13);
    checks++;
    if (out0_count !== 2'd2 || out1_count !== 2'd2) begin
      errors++; $display("FAIL arst_prefill: c0=%0d c1=%0d expected 2 2", out0_count, out1_count);
    end
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_count !== 2'd0 || out1_count !== 2'd0 ||
        out0_data !== 32'h0 || out1_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: v0=%b v1=%b c0=%0d c1=%0d d0=%h d1=%h rdy=%b expected all 0",
                         out0_valid, out1_valid, out0_count, out1_count, out0_data, out1_data, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    push(1'b1, 32'h5);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h5 || out1_count !== 2'd1 ||
        out0_valid !== 1'b0 || out0_count !== 2'd0) begin
      errors++; $display("FAIL arst_fresh: v1=%b d1=%h c1=%0d v0=%b c0=%0d expected 1 5 1 0 0",
                         out1_valid, out1_data, out1_count, out0_valid, out0_count);
    end
    out1_ready = 1'b1; tick(); out1_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pushpop();
    test_interleave();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
